xor_descrambler: RTL and testbench
==================================

# xor_descrambler

Self-synchronizing multiplicative descrambler: the receive-side inverse of the XOR scrambler datapath built from the bitwise-XOR primitive. Each accepted word of scrambled bits is XORed with delayed copies of earlier scrambled bits, polynomial 1 + x^TAP + x^LEN. The block sits between the link deserializer and the payload consumer, with a registered output stage and ready/valid flow control on both sides. It reports lock once enough scrambled history has been absorbed.

## Interface
- WIDTH, 8: bits per word; must be ≥ 1.
- LEN, 7: polynomial degree, which is the history depth in bits; must be ≥ 2.
- TAP, 4: inner tap; must satisfy 1 ≤ TAP < LEN.
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- CLR  input  1  synchronous history/lock clear; does not touch the output register.
- I  input  WIDTH  scrambled word; bit 0 is the earliest bit on the line.
- I_valid  input  1  I is valid.
- I_ready  output  1  block accepts I this cycle.
- O  output  WIDTH  descrambled word; bit 0 is the earliest bit.
- O_valid  output  1  O is valid.
- O_ready  input  1  consumer accepts O this cycle.
- O_locked  output  1  O is trustworthy: at least LEN scrambled bits were absorbed since the last reset or clear.

## Operation
- Serial definition: d[k] = s[k] ^ s[k-TAP] ^ s[k-LEN], where s is the scrambled input stream and d is the output stream. Bits before reset or clear are treated as 0.
- Per-word evaluation:
  - Form the vector {I, hist}, where hist holds the previous LEN scrambled bits and hist[LEN-1] is the most recent.
  - Compute each output bit with this rule.
  - All indices are static, so the logic is purely combinational XOR.
  - WIDTH may be less than, equal to or greater than LEN.
- History update, on accept only: hist ← the last LEN bits of {I, hist}.
- Accept condition: I_valid && I_ready.
- Lock counter:
  - cnt has width clog2(LEN+1).
  - On accept, cnt ← min(cnt + WIDTH, LEN).
  - cnt saturates at LEN.
  - O_locked = (cnt == LEN).
- Output qualification: a word accepted while unlocked is still emitted. Its lock state at emission time is reflected by O_locked, so consumers may discard it.
- CLR:
  - Same cycle as an accept: CLR wins for hist and cnt, so the accepted word does not enter history.
  - That word is still descrambled using the old history and emitted.
- No state machine: the block is a one-stage pipeline plus a saturating counter.

## Timing
- Reset values: O=0, O_valid=0, O_locked=0, hist=0, cnt=0. While RESET is high, I_ready=0.
- Latency: 1 cycle. A word accepted in cycle n appears on O with O_valid=1 in cycle n+1.
- I_ready = !O_valid || O_ready, combinational.
- Throughput: one word per cycle with O_ready held high.
- O holds stable while O_valid && !O_ready.
- Simultaneous pop and push: O_valid stays 1 and O takes the new word.
- O_locked is registered with cnt and changes on the same edge as the accept that completes LEN bits.
- RESET mid-stream: the output word in flight is dropped (O_valid=0 next cycle), hist and cnt clear, and lock must be reacquired.

## Structure
- Shared package `xor_scrambler_pkg`:
  - defaults DEFAULT_WIDTH=8, DEFAULT_LEN=7, DEFAULT_TAP=4;
  - a lock-count width helper, used by both the scrambler and the descrambler.
- One combinational sub-module, `xor_descramble_step`:
  - inputs: hist, I;
  - outputs: O word, next hist;
  - the scrambler reuses the same indexing.
- Top level: output register, handshake, lock counter.

## Test plan
- Reset, then I=0x00 with I_valid held (WIDTH=8, LEN=7, TAP=4) → O=0x00 from cycle 1 onward; O_locked=1 in the cycle O_valid first rises.
- After reset, single word I=0x01 → O=0x91 (bits 0, 4, 7 set) one cycle later.
- Scrambler model feeds 256 random words, stream starting at reset → all outputs after lock equal the plaintext.
- Bench seeded into a non-zero scrambler state → recovers data after the first word.
- Backpressure: O_ready=0 for 5 cycles during a stream → O and O_valid hold, I_ready=0, and no word is lost or duplicated once O_ready returns.
- WIDTH=3, LEN=7 → O_locked rises on the edge of the third accept (cnt 3, 6, 7).
- CLR asserted with an accept → that word is emitted, O_locked=0 next cycle, and a subsequent I=0x01 yields O=0x91.
- RESET asserted while O_valid=1 and O_ready=0 → O_valid=0 and O=0 next cycle; I_ready=0 during reset.

Source files
------------

// File: rtl/xor_scrambler_pkg.sv
// Shared definitions for the multiplicative XOR scrambler/descrambler pair:
// default polynomial parameters and the lock-counter width helper.
package xor_scrambler_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_LEN   = 7;
  localparam int unsigned DEFAULT_TAP   = 4;

  // Counter must hold values 0..len inclusive.
  function automatic int unsigned lock_cnt_width(input int unsigned len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/xor_descramble_step.sv
// One word of self-synchronizing descrambling, polynomial 1 + x^TAP + x^LEN.
// Purely combinational: static XOR taps into the {I, hist} vector.
module xor_descramble_step
  import xor_scrambler_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned LEN   = DEFAULT_LEN,
  parameter int unsigned TAP   = DEFAULT_TAP
) (
  input  logic [LEN-1:0]   hist,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic [LEN-1:0]   hist_next
);

  // hist[LEN-1] is the most recent bit, so v[LEN+j] is bit j of the word and
  // v[LEN+j-k] is the scrambled bit k positions earlier on the line.
  logic [WIDTH+LEN-1:0] v;

  assign v = {I, hist};

  always_comb begin
    O = '0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      O[j] = v[LEN+j] ^ v[LEN+j-TAP] ^ v[j];
    end
  end

  assign hist_next = v[WIDTH+LEN-1 -: LEN];

endmodule

// File: rtl/xor_descrambler.sv
// Registered descrambler stage with ready/valid on both sides and a
// saturating lock counter tracking how much scrambled history was absorbed.
module xor_descrambler
  import xor_scrambler_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned LEN   = DEFAULT_LEN,
  parameter int unsigned TAP   = DEFAULT_TAP
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLR,
  input  logic [WIDTH-1:0] I,
  input  logic             I_valid,
  output logic             I_ready,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  input  logic             O_ready,
  output logic             O_locked
);

  localparam int unsigned CNT_W = lock_cnt_width(LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LEN);

  logic [WIDTH-1:0] o_q, o_d;
  logic             o_valid_q, o_valid_d;
  logic [LEN-1:0]   hist_q, hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] step_o;
  logic [LEN-1:0]   step_hist;
  logic             accept;
  logic [31:0]      cnt_sum;

  xor_descramble_step #(
    .WIDTH(WIDTH),
    .LEN  (LEN),
    .TAP  (TAP)
  ) u_step (
    .hist     (hist_q),
    .I        (I),
    .O        (step_o),
    .hist_next(step_hist)
  );

  assign I_ready = !RESET && (!o_valid_q || O_ready);
  assign accept  = I_valid && I_ready;
  assign cnt_sum = 32'(cnt_q) + 32'(WIDTH);

  always_comb begin
    o_d       = o_q;
    o_valid_d = o_valid_q;
    hist_d    = hist_q;
    cnt_d     = cnt_q;

    if (accept) begin
      o_d       = step_o;
      o_valid_d = 1'b1;
    end else if (O_ready) begin
      o_valid_d = 1'b0;
    end

    // CLR takes priority over the accept for history and lock, but the word
    // descrambled from the old history above is still emitted.
    if (CLR) begin
      hist_d = '0;
      cnt_d  = '0;
    end else if (accept) begin
      hist_d = step_hist;
      cnt_d  = (cnt_sum >= 32'(LEN)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      o_q       <= '0;
      o_valid_q <= 1'b0;
      hist_q    <= '0;
      cnt_q     <= '0;
    end else begin
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      hist_q    <= hist_d;
      cnt_q     <= cnt_d;
    end
  end

  assign O        = o_q;
  assign O_valid  = o_valid_q;
  assign O_locked = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_xor_descrambler.sv
// Self-checking bench for xor_descrambler: bit-serial reference model of the
// scrambler and descrambler, plus directed handshake, lock, clear and reset steps.
module tb_xor_descrambler;

  localparam int L = 7;
  localparam int T = 4;

  logic       CLK = 1'b0;
  logic       RESET, CLR;
  logic [7:0] I, O;
  logic       I_valid, I_ready, O_valid, O_ready, O_locked;
  logic [2:0] I3, O3;
  logic       I3_valid, I3_ready, O3_valid, O3_ready, O3_locked;

  int tests = 0;
  int fails = 0;

  bit mq[$];     // scrambled bits absorbed by the DUT since reset/clear (last L kept)
  int absorbed;  // total bits absorbed since reset/clear
  bit sq[$];     // reference scrambler's own output history (last L kept)

  always #5 CLK = ~CLK;

  xor_descrambler #(.WIDTH(8), .LEN(L), .TAP(T)) dut (
    .CLK(CLK), .RESET(RESET), .CLR(CLR),
    .I(I), .I_valid(I_valid), .I_ready(I_ready),
    .O(O), .O_valid(O_valid), .O_ready(O_ready), .O_locked(O_locked)
  );

  xor_descrambler #(.WIDTH(3), .LEN(L), .TAP(T)) dut3 (
    .CLK(CLK), .RESET(RESET), .CLR(CLR),
    .I(I3), .I_valid(I3_valid), .I_ready(I3_ready),
    .O(O3), .O_valid(O3_valid), .O_ready(O3_ready), .O_locked(O3_locked)
  );

  function automatic bit qget(input bit q[$], input int idx);
    if (idx < 0) return 1'b0;
    return q[idx];
  endfunction

  // d[k] = s[k] ^ s[k-T] ^ s[k-L], with bits before reset/clear taken as 0
  function automatic logic [7:0] model_out(input logic [7:0] w);
    bit tmp[$];
    int n;
    logic [7:0] d;
    tmp = mq;
    for (int j = 0; j < 8; j++) begin
      tmp.push_back(w[j]);
      n = tmp.size() - 1;
      d[j] = tmp[n] ^ qget(tmp, n - T) ^ qget(tmp, n - L);
    end
    return d;
  endfunction

  function automatic void model_commit(input logic [7:0] w);
    for (int j = 0; j < 8; j++) begin
      mq.push_back(w[j]);
      if (mq.size() > L) void'(mq.pop_front());
    end
    absorbed += 8;
  endfunction

  function automatic void model_clear();
    mq.delete();
    absorbed = 0;
  endfunction

  // s[k] = p[k] ^ s[k-T] ^ s[k-L]
  function automatic logic [7:0] scramble(input logic [7:0] p);
    logic [7:0] s;
    int n;
    for (int j = 0; j < 8; j++) begin
      n = sq.size();
      s[j] = p[j] ^ qget(sq, n - T) ^ qget(sq, n - L);
      sq.push_back(s[j]);
      if (sq.size() > L) void'(sq.pop_front());
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    I_valid = 1'b0;
    I3_valid = 1'b0;
    O_ready = 1'b1;
    O3_ready = 1'b1;
    #1;
    chk("i_ready_in_reset", I_ready, 0);
    step();
    step();
    RESET = 1'b0;
    chk("rst_o", O, 0);
    chk("rst_o_valid", O_valid, 0);
    chk("rst_o_locked", O_locked, 0);
    model_clear();
  endtask

  // Push one word with O_ready high; check output against the reference model.
  task automatic send(input logic [7:0] s, output logic [7:0] got);
    logic [7:0] exp;
    exp = model_out(s);
    I = s;
    I_valid = 1'b1;
    #1;
    chk("send_i_ready", I_ready, 1);
    step();
    I_valid = 1'b0;
    got = O;
    model_commit(s);
    chk("send_o_valid", O_valid, 1);
    chk("send_o", O, exp);
    chk("send_o_locked", O_locked, (absorbed >= L) ? 1 : 0);
  endtask

  initial begin
    logic [7:0] got, p, s, a_exp, b, b_exp;

    RESET = 1'b1; CLR = 1'b0; I = '0; I_valid = 1'b0; O_ready = 1'b1;
    I3 = '0; I3_valid = 1'b0; O3_ready = 1'b1;
    absorbed = 0;

    // All-zero stream: zero output, locked as soon as O_valid first rises
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(8'h00, got);
      chk("zero_o", got, 8'h00);
    end
    chk("zero_locked", O_locked, 1);

    // Single impulse
    do_reset();
    send(8'h01, got);
    chk("impulse", got, 8'h91);

    // Random plaintext through reference scrambler, both starting from zero
    do_reset();
    sq.delete();
    for (int i = 0; i < 256; i++) begin
      p = 8'($urandom);
      s = scramble(p);
      send(s, got);
      if (absorbed >= L) chk("rand_plain", got, p);
    end

    // Scrambler seeded into a non-zero state: recovered after the first word
    do_reset();
    sq.delete();
    for (int i = 0; i < L; i++) sq.push_back(bit'($urandom));
    sq[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      p = 8'($urandom);
      s = scramble(p);
      send(s, got);
      if (i >= 1) chk("seed_plain", got, p);
    end

    // Backpressure: hold for 5 cycles, then exactly one new word
    send(8'($urandom), got);
    a_exp = got;
    b = 8'($urandom);
    O_ready = 1'b0;
    I = b;
    I_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_i_ready", I_ready, 0);
      step();
      chk("bp_o_valid", O_valid, 1);
      chk("bp_o_hold", O, a_exp);
    end
    O_ready = 1'b1;
    #1;
    chk("bp_release_ready", I_ready, 1);
    b_exp = model_out(b);
    step();
    I_valid = 1'b0;
    model_commit(b);
    chk("bp_o_new", O, b_exp);
    chk("bp_o_valid_new", O_valid, 1);
    step();
    chk("bp_no_dup", O_valid, 0);

    // CLR coincident with an accept
    s = 8'($urandom);
    a_exp = model_out(s);
    I = s;
    I_valid = 1'b1;
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    I_valid = 1'b0;
    chk("clr_o", O, a_exp);
    chk("clr_o_valid", O_valid, 1);
    chk("clr_unlocked", O_locked, 0);
    model_clear();
    send(8'h01, got);
    chk("clr_impulse", got, 8'h91);

    // WIDTH=3: lock on the third accept (cnt 3, 6, 7)
    do_reset();
    I3 = 3'b001;
    I3_valid = 1'b1;
    step();
    chk("w3_o1", O3, 3'b001);
    chk("w3_valid1", O3_valid, 1);
    chk("w3_lock1", O3_locked, 0);
    I3 = 3'b000;
    step();
    chk("w3_o2", O3, 3'b010);
    chk("w3_lock2", O3_locked, 0);
    step();
    chk("w3_o3", O3, 3'b010);
    chk("w3_lock3", O3_locked, 1);
    I3_valid = 1'b0;

    // RESET while a word is held under backpressure
    send(8'($urandom), got);
    O_ready = 1'b0;
    step();
    chk("rst_mid_held", O_valid, 1);
    RESET = 1'b1;
    #1;
    chk("rst_mid_i_ready", I_ready, 0);
    step();
    chk("rst_mid_o_valid", O_valid, 0);
    chk("rst_mid_o", O, 0);
    chk("rst_mid_locked", O_locked, 0);
    RESET = 1'b0;
    O_ready = 1'b1;
    model_clear();
    send(8'h01, got);
    chk("rst_mid_impulse", got, 8'h91);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
